edge_event_scheduler: RTL and testbench



---
 rtl/edge_sched_pkg.sv | 15 +
 rtl/edge_sync_detect.sv | 58 +++++
 rtl/edge_event_scheduler.sv | 153 +++++++++++++++
 tb/tb_edge_event_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_sched_pkg.sv
// Shared constants for the edge event scheduler: per-channel edge-mode
// encodings and the arbiter state type.
package edge_sched_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } sched_state_t;

endpackage

// File: rtl/edge_sync_detect.sv
// One channel of the scheduler front end: synchronizer chain, history flop
// and edge-mode qualification of the synchronized pulse.
module edge_sync_detect
  import edge_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pulse,
  input  logic [1:0] i_mode,
  input  logic       i_qual,
  output logic       o_det,
  output logic       o_det_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   sync_s;
  logic                   rise, fall;
  logic                   mode_hit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_pulse};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist_q;
  assign fall   = ~sync_s & hist_q;

  always_comb begin
    mode_hit = 1'b0;
    case (i_mode)
      EDGE_OFF:  mode_hit = 1'b0;
      EDGE_RISE: mode_hit = rise;
      EDGE_FALL: mode_hit = fall;
      EDGE_BOTH: mode_hit = rise | fall;
      default:   mode_hit = 1'b0;
    endcase
  end

  // History keeps tracking even when unqualified, so re-enabling never
  // produces a stale edge.
  assign o_det      = i_qual & mode_hit;
  assign o_det_rise = rise;

endmodule

// File: rtl/edge_event_scheduler.sv
// Per-channel edge detection feeding single-slot pending stores, drained
// through one valid/ready event port by a round-robin arbiter.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CHW         = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   i_pulse,
  input  logic [2*N_CH-1:0] i_edge_mode,
  input  logic              i_enable,
  output logic              o_evt_valid,
  input  logic              i_evt_ready,
  output logic [CHW-1:0]    o_evt_ch,
  output logic              o_evt_rise,
  output logic [N_CH-1:0]   o_pending,
  output logic [N_CH-1:0]   o_overflow,
  input  logic              i_ovf_clr
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARMW    = $clog2(ARM_MAX + 1);

  sched_state_t    state_q, state_d;
  logic [ARMW-1:0] arm_q, arm_d;
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [CHW-1:0]  evt_ch_q, evt_ch_d;
  logic            evt_rise_q, evt_rise_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] slot_rise_q, slot_rise_d;
  logic [N_CH-1:0] ovf_q, ovf_d;

  logic            armed;
  logic [N_CH-1:0] det, det_rise;
  logic            any_pend;
  logic [CHW-1:0]  win;
  logic            grant;

  assign armed = (arm_q == ARMW'(ARM_MAX));

  always_comb begin
    arm_d = armed ? arm_q : arm_q + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_sync_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .clk       (clk),
      .rst       (rst),
      .i_pulse   (i_pulse[i]),
      .i_mode    (i_edge_mode[2*i+1:2*i]),
      .i_qual    (armed & i_enable),
      .o_det     (det[i]),
      .o_det_rise(det_rise[i])
    );
  end

  // Round-robin search starts just after the last winner.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr_q) + k) % N_CH;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = CHW'(idx);
      end
    end
  end

  assign any_pend = |pend_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    evt_ch_d   = evt_ch_q;
    evt_rise_d = evt_rise_q;
    grant      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) grant = 1'b1;
      end
      ST_OFFER: begin
        if (i_evt_ready) begin
          if (any_pend) grant = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      state_d    = ST_OFFER;
      ptr_d      = win;
      evt_ch_d   = win;
      evt_rise_d = slot_rise_q[win];
    end
  end

  // A slot released by this cycle's grant is free for a same-cycle edge;
  // a set of an overflow bit beats a simultaneous clear.
  always_comb begin
    pend_d      = pend_q;
    slot_rise_d = slot_rise_q;
    ovf_d       = i_ovf_clr ? '0 : ovf_q;
    if (grant) pend_d[win] = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (det[i]) begin
        if (pend_d[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          slot_rise_d[i] = det_rise[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      arm_q       <= '0;
      ptr_q       <= CHW'(N_CH - 1);
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      pend_q      <= '0;
      slot_rise_q <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      ptr_q       <= ptr_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      pend_q      <= pend_d;
      slot_rise_q <= slot_rise_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_evt_valid = (state_q == ST_OFFER);
  assign o_evt_ch    = evt_ch_q;
  assign o_evt_rise  = evt_rise_q;
  assign o_pending   = pend_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: event-level reference model checked every
// cycle, plus directed scenarios with hand-derived expectations.
module tb_edge_event_scheduler;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int CHW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   i_pulse;
  logic [2*N_CH-1:0] i_edge_mode;
  logic              i_enable;
  logic              o_evt_valid;
  logic              i_evt_ready;
  logic [CHW-1:0]    o_evt_ch;
  logic              o_evt_rise;
  logic [N_CH-1:0]   o_pending;
  logic [N_CH-1:0]   o_overflow;
  logic              i_ovf_clr;

  edge_event_scheduler #(.N_CH(N_CH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pulse    (i_pulse),
    .i_edge_mode(i_edge_mode),
    .i_enable   (i_enable),
    .o_evt_valid(o_evt_valid),
    .i_evt_ready(i_evt_ready),
    .o_evt_ch   (o_evt_ch),
    .o_evt_rise (o_evt_rise),
    .o_pending  (o_pending),
    .o_overflow (o_overflow),
    .i_ovf_clr  (i_ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the pin is seen SYNC cycles late, its previous value
  // SYNC+1 cycles late; each channel owns one slot; one offered event.
  logic [N_CH-1:0] m_samp [SYNC+1];
  logic [N_CH-1:0] m_pend, m_rise, m_ovf;
  logic            m_valid, m_evrise;
  int              m_ch, m_last, m_since;

  task automatic model_reset();
    for (int k = 0; k <= SYNC; k++) m_samp[k] = '0;
    m_pend = '0; m_rise = '0; m_ovf = '0;
    m_valid = 1'b0; m_evrise = 1'b0; m_ch = 0;
    m_last = N_CH - 1; m_since = 0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] seen, prev, nextp;
    logic up, dn, want;
    int w;
    seen  = m_samp[SYNC-1];
    prev  = m_samp[SYNC];
    nextp = m_pend;
    if (m_valid && i_evt_ready) m_valid = 1'b0;
    if (!m_valid && m_pend != '0) begin
      w = -1;
      for (int k = 1; k <= N_CH; k++)
        if (w < 0 && m_pend[(m_last + k) % N_CH]) w = (m_last + k) % N_CH;
      m_valid  = 1'b1;
      m_ch     = w;
      m_evrise = m_rise[w];
      nextp[w] = 1'b0;
      m_last   = w;
    end
    if (i_ovf_clr) m_ovf = '0;
    if (m_since >= SYNC + 1 && i_enable) begin
      for (int c = 0; c < N_CH; c++) begin
        up   = seen[c] & ~prev[c];
        dn   = ~seen[c] & prev[c];
        want = (up && i_edge_mode[2*c]) || (dn && i_edge_mode[2*c+1]);
        if (want) begin
          if (nextp[c]) m_ovf[c] = 1'b1;
          else begin
            nextp[c]  = 1'b1;
            m_rise[c] = up;
          end
        end
      end
    end
    m_pend = nextp;
    for (int k = SYNC; k >= 1; k--) m_samp[k] = m_samp[k-1];
    m_samp[0] = i_pulse;
    if (m_since < 1000) m_since++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Accepted-event log and per-cycle comparison against the model.
  int   acc_ch[$];
  int   acc_rise[$];
  int   acc_t[$];
  int   ncyc = 0;
  logic seen_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", o_evt_valid, 0);
      chk("rst_ch", o_evt_ch, 0);
      chk("rst_rise", o_evt_rise, 0);
      chk("rst_pending", o_pending, 0);
      chk("rst_overflow", o_overflow, 0);
    end else begin
      chk("model_valid", o_evt_valid, m_valid);
      chk("model_pending", o_pending, m_pend);
      chk("model_overflow", o_overflow, m_ovf);
      if (m_valid) begin
        chk("model_ch", o_evt_ch, m_ch);
        chk("model_rise", o_evt_rise, m_evrise);
      end
      if (o_evt_valid) seen_valid = 1'b1;
      if (o_evt_valid && i_evt_ready) begin
        acc_ch.push_back(int'(o_evt_ch));
        acc_rise.push_back(int'(o_evt_rise));
        acc_t.push_back(ncyc);
      end
    end
    ncyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    acc_ch.delete();
    acc_rise.delete();
    acc_t.delete();
  endtask

  task automatic check_evt(input string nm, input int idx, input int ch, input int rise);
    if (idx < acc_ch.size()) begin
      chk({nm, "_ch"}, acc_ch[idx], ch);
      chk({nm, "_rise"}, acc_rise[idx], rise);
    end else begin
      chk({nm, "_missing"}, acc_ch.size(), idx + 1);
    end
  endtask

  task automatic check_b2b(input string nm);
    if (acc_t.size() == 3) begin
      chk({nm, "_gap1"}, acc_t[1] - acc_t[0], 1);
      chk({nm, "_gap2"}, acc_t[2] - acc_t[1], 1);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (o_evt_valid) break;
    end
  endtask

  int n;

  initial begin
    rst = 1'b0; i_pulse = 4'b0001; i_edge_mode = 8'h55; i_enable = 1'b1;
    i_evt_ready = 1'b0; i_ovf_clr = 1'b0;
    #1 rst = 1'b1;
    tick(3);

    // Arm window: ch0 already high at release must not fire.
    rst = 1'b0;
    seen_valid = 1'b0;
    tick(20);
    chk("arm_no_event", seen_valid, 0);
    chk("arm_pending", o_pending, 0);
    i_pulse = '0;
    tick(5);

    // Latency on ch2 in both-edge mode.
    i_edge_mode = 8'h75;
    i_evt_ready = 1'b1;
    i_pulse[2] = 1'b1;
    wait_valid(n);
    chk("lat_rise_cycles", n - 1, 3);
    chk("lat_rise_ch", o_evt_ch, 2);
    chk("lat_rise_type", o_evt_rise, 1);
    tick(50);
    i_pulse[2] = 1'b0;
    wait_valid(n);
    chk("lat_fall_cycles", n - 1, 3);
    chk("lat_fall_ch", o_evt_ch, 2);
    chk("lat_fall_type", o_evt_rise, 0);
    tick(5);

    // Round-robin from a fresh reset.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    i_edge_mode = 8'h55;
    i_evt_ready = 1'b0;
    tick(6);
    clear_log();
    i_pulse = 4'b1011;
    tick(10);
    chk("rr1_hold_ch", o_evt_ch, 0);
    i_evt_ready = 1'b1;
    tick(6);
    chk("rr1_count", acc_ch.size(), 3);
    check_evt("rr1_e0", 0, 0, 1);
    check_evt("rr1_e1", 1, 1, 1);
    check_evt("rr1_e2", 2, 3, 1);
    check_b2b("rr1");
    i_pulse = '0;
    i_evt_ready = 1'b0;
    tick(5);
    clear_log();
    i_pulse = 4'b1011;
    tick(10);
    i_evt_ready = 1'b1;
    tick(6);
    chk("rr2_count", acc_ch.size(), 3);
    check_evt("rr2_e0", 0, 0, 1);
    check_evt("rr2_e1", 1, 1, 1);
    check_evt("rr2_e2", 2, 3, 1);
    check_b2b("rr2");

    // Backpressure: offer register plus slot absorb two edges, third drops.
    i_pulse = '0;
    i_evt_ready = 1'b0;
    tick(5);
    clear_log();
    i_pulse[1] = 1'b1; tick(20);
    i_pulse[1] = 1'b0; tick(20);
    i_pulse[1] = 1'b1; tick(10);
    chk("bp_valid", o_evt_valid, 1);
    chk("bp_ch", o_evt_ch, 1);
    chk("bp_pend1", o_pending[1], 1);
    chk("bp_ovf_before", o_overflow[1], 0);
    i_pulse[1] = 1'b0; tick(10);
    i_pulse[1] = 1'b1; tick(10);
    chk("bp_ovf_set", o_overflow[1], 1);
    chk("bp_ch_hold", o_evt_ch, 1);
    i_ovf_clr = 1'b1; tick(1);
    i_ovf_clr = 1'b0;
    chk("ovf_cleared", o_overflow[1], 0);
    i_pulse[1] = 1'b0; tick(10);
    i_pulse[1] = 1'b1;
    tick(2);
    i_ovf_clr = 1'b1; tick(1);
    i_ovf_clr = 1'b0;
    chk("ovf_collide_set_wins", o_overflow[1], 1);
    i_ovf_clr = 1'b1; tick(1);
    i_ovf_clr = 1'b0;
    i_evt_ready = 1'b1;
    tick(5);
    chk("bp_delivered", acc_ch.size(), 2);
    check_evt("bp_e0", 0, 1, 1);
    check_evt("bp_e1", 1, 1, 1);
    chk("bp_drained", o_pending, 0);
    i_pulse = '0;
    tick(3);

    // Enable gating, then fall-only mode on ch0.
    i_enable = 1'b0;
    i_edge_mode = 8'hFF;
    clear_log();
    i_pulse = 4'hF; tick(10);
    i_pulse = 4'h0; tick(10);
    i_enable = 1'b1;
    tick(10);
    chk("en_off_events", acc_ch.size(), 0);
    i_edge_mode = 8'b0000_0010;
    clear_log();
    i_pulse[0] = 1'b1; tick(10);
    i_pulse[0] = 1'b0; tick(10);
    chk("fall_only_count", acc_ch.size(), 1);
    check_evt("fall_only", 0, 0, 0);

    // Reset while an event is offered and unaccepted.
    i_edge_mode = 8'h55;
    i_evt_ready = 1'b0;
    clear_log();
    i_pulse = 4'b1100;
    tick(8);
    chk("ro_valid", o_evt_valid, 1);
    chk("ro_ch", o_evt_ch, 2);
    chk("ro_pend3", o_pending[3], 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ro_async_valid", o_evt_valid, 0);
    chk("ro_async_ch", o_evt_ch, 0);
    chk("ro_async_pending", o_pending, 0);
    chk("ro_async_overflow", o_overflow, 0);
    tick(2);
    i_pulse = '0;
    rst = 1'b0;
    tick(6);
    clear_log();
    i_pulse = 4'b1010;
    tick(8);
    i_evt_ready = 1'b1;
    tick(5);
    chk("ro_after_count", acc_ch.size(), 2);
    check_evt("ro_after_e0", 0, 1, 1);
    check_evt("ro_after_e1", 1, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
